acc_drain: RTL and testbench

Drain and quantize stage directly downstream of the per-column accumulator FIFOs. After a tile finishes, it pops one row of ARRAY_SIZE partial sums at a time, with all lanes popped together. Each 24-bit signed sum is rounded, shifted, optionally ReLU-clamped and saturated to 8 bits. The packed row is then presented to the output/activation buffer over a valid/ready handshake.

---
 rtl/acc_pkg.sv | 30 +++
 rtl/acc_quant_lane.sv | 44 ++++
 rtl/acc_drain.sv | 145 ++++++++++++++
 tb/tb_acc_drain.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared constants, drain FSM encoding and saturation helpers for the
// accumulator drain/quantize stage.
package acc_pkg;

  localparam int ARRAY_SIZE = 8;
  localparam int DATA_SIZE  = 24;
  localparam int OUT_SIZE   = 8;
  localparam int TIMEOUT    = 255;
  localparam int SHIFT_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4
  } drain_state_t;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int SAT_MAX = sat_max(OUT_SIZE);
  localparam int SAT_MIN = sat_min(OUT_SIZE);

endpackage

// File: rtl/acc_quant_lane.sv
// One lane of the quantizer: round-half-up arithmetic shift, optional ReLU,
// then saturation to the signed output width. Purely combinational.
module acc_quant_lane #(
  parameter int DATA_SIZE = acc_pkg::DATA_SIZE,
  parameter int OUT_SIZE  = acc_pkg::OUT_SIZE
) (
  input  logic [DATA_SIZE-1:0] x,
  input  logic [4:0]           shift,
  input  logic                 relu_en,
  output logic [OUT_SIZE-1:0]  y
);
  import acc_pkg::*;

  // One extra bit so the rounding add cannot wrap at the top of the range.
  localparam int EW = DATA_SIZE + 1;
  localparam logic signed [EW-1:0] HI = EW'(sat_max(OUT_SIZE));
  localparam logic signed [EW-1:0] LO = EW'(sat_min(OUT_SIZE));

  logic signed [EW-1:0] xe;
  logic signed [EW-1:0] half;
  logic signed [EW-1:0] shifted;

  always_comb begin
    xe      = {x[DATA_SIZE-1], x};
    half    = '0;
    shifted = xe;
    y       = '0;
    if (shift != 5'd0) begin
      half    = EW'(1) << (shift - 5'd1);
      shifted = (xe + half) >>> shift;
    end
    if (relu_en && shifted[EW-1]) begin
      shifted = '0;
    end
    if (shifted > HI) begin
      y = HI[OUT_SIZE-1:0];
    end else if (shifted < LO) begin
      y = LO[OUT_SIZE-1:0];
    end else begin
      y = shifted[OUT_SIZE-1:0];
    end
  end

endmodule

// File: rtl/acc_drain.sv
// Drains one tile from the per-column accumulator FIFOs a row at a time,
// quantizes every lane and presents the packed row on a valid/ready port.
module acc_drain #(
  parameter int ARRAY_SIZE = acc_pkg::ARRAY_SIZE,
  parameter int DATA_SIZE  = acc_pkg::DATA_SIZE,
  parameter int OUT_SIZE   = acc_pkg::OUT_SIZE,
  parameter int TIMEOUT    = acc_pkg::TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [4:0]                     shift,
  input  logic                           relu_en,
  input  logic [ARRAY_SIZE-1:0]          acc_empty,
  input  logic [ARRAY_SIZE*DATA_SIZE-1:0] acc_data,
  output logic [ARRAY_SIZE-1:0]          acc_rd_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ARRAY_SIZE*OUT_SIZE-1:0] out_data,
  output logic                           busy,
  output logic                           done,
  output logic                           err_timeout,
  output logic [2:0]                     state_dbg
);
  import acc_pkg::*;

  localparam int ROW_W  = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ARRAY_SIZE - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  drain_state_t state;
  drain_state_t state_d;

  logic [4:0]                     shift_q;
  logic                           relu_q;
  logic [ROW_W-1:0]               row_cnt;
  logic [WAIT_W-1:0]              wait_cnt;
  logic                           err_q;
  logic [ARRAY_SIZE*OUT_SIZE-1:0] out_data_q;
  logic [ARRAY_SIZE*OUT_SIZE-1:0] quant;

  logic all_ready;
  logic pop;
  logic start_ok;
  logic accept;

  assign all_ready = ~|acc_empty;
  assign start_ok  = (state == ST_IDLE) && start;
  assign pop       = (state == ST_ISSUE) && all_ready;

  // Output handshake: a row transfers on any rising edge where out_valid and
  // out_ready are both high; out_valid never drops and out_data never changes
  // until that transfer happens (reset excepted).
  assign accept    = (state == ST_HOLD) && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (all_ready) begin
          state_d = ST_CAPTURE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          state_d = (row_cnt == LAST_ROW) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      relu_q     <= 1'b0;
      row_cnt    <= '0;
      wait_cnt   <= '0;
      err_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (start_ok) begin
        shift_q  <= shift;
        relu_q   <= relu_en;
        row_cnt  <= '0;
        wait_cnt <= '0;
        err_q    <= 1'b0;
      end
      if (state == ST_ISSUE) begin
        if (all_ready) begin
          wait_cnt <= '0;
        end else if (wait_cnt == WAIT_LAST) begin
          wait_cnt <= '0;
          err_q    <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
      // FIFO output is registered, so the popped row is on acc_data now.
      if (state == ST_CAPTURE) begin
        out_data_q <= quant;
      end
      if (accept) begin
        row_cnt <= row_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    acc_quant_lane #(
      .DATA_SIZE(DATA_SIZE),
      .OUT_SIZE (OUT_SIZE)
    ) u_lane (
      .x      (acc_data[i*DATA_SIZE +: DATA_SIZE]),
      .shift  (shift_q),
      .relu_en(relu_q),
      .y      (quant[i*OUT_SIZE +: OUT_SIZE])
    );
  end

  assign acc_rd_en   = {ARRAY_SIZE{pop}};
  assign out_valid   = (state == ST_HOLD);
  assign out_data    = out_data_q;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign err_timeout = err_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_acc_drain.sv
// Bench for acc_drain: FIFO model, table vectors, corner-case sequences and
// randomized tiles checked against an arithmetic quantization model.
module tb_acc_drain;
  import acc_pkg::*;

  localparam int N  = ARRAY_SIZE;
  localparam int DW = DATA_SIZE;
  localparam int OW = OUT_SIZE;

  logic            clk;
  logic            rst;
  logic            start;
  logic [4:0]      shift;
  logic            relu_en;
  logic [N-1:0]    acc_empty;
  logic [N*DW-1:0] acc_data;
  logic [N-1:0]    acc_rd_en;
  logic            out_valid;
  logic            out_ready;
  logic [N*OW-1:0] out_data;
  logic            busy;
  logic            done;
  logic            err_timeout;
  logic [2:0]      state_dbg;

  acc_drain dut (
    .clk(clk), .rst(rst), .start(start), .shift(shift), .relu_en(relu_en),
    .acc_empty(acc_empty), .acc_data(acc_data), .acc_rd_en(acc_rd_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  int n_rd     = 0;
  int n_acc    = 0;

  logic [N*OW-1:0] exp_q[$];
  logic [DW-1:0]   fq[N][$];
  logic [DW-1:0]   pend[N][$];

  typedef struct packed {
    logic [4:0]           sh;
    logic                 relu;
    logic [N-1:0][DW-1:0] x;
    logic [N-1:0][OW-1:0] y;
  } vec_t;
  vec_t tbl[6];
  int xs[N];
  int ys[N];
  logic [N*DW-1:0] rows[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // reference model
  function automatic logic [OW-1:0] ref_quant(input int x, input int sh, input logic relu);
    longint y;
    y = x;
    if (sh > 0) y = (y + (longint'(1) <<< (sh - 1))) >>> sh;
    if (relu && y < 0) y = 0;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return OW'(y);
  endfunction

  function automatic logic [N*OW-1:0] ref_row(input logic [N*DW-1:0] r, input int sh, input logic relu);
    logic [N*OW-1:0] e;
    e = '0;
    for (int i = 0; i < N; i++) e[i*OW +: OW] = ref_quant(int'($signed(r[i*DW +: DW])), sh, relu);
    return e;
  endfunction

  function automatic logic [N*DW-1:0] rand_row(input int sh);
    logic [N*DW-1:0] r;
    int span;
    int x;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 2))
        0: x = int'($urandom_range(0, 600)) - 300;
        1: begin
          span = 1 << ((sh + 8 > 23) ? 23 : sh + 8);
          x = int'($urandom_range(0, 2 * span)) - span;
        end
        default: x = int'($urandom);
      endcase
      r[i*DW +: DW] = DW'(x);
    end
    return r;
  endfunction

  // accumulator FIFO model: registered read data, writes visible after an edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        fq[i].delete();
        pend[i].delete();
      end
      acc_data  <= '0;
      acc_empty <= '1;
    end else begin
      if (acc_rd_en != '0) begin
        check("rd_all_lanes", 64'(acc_rd_en), 64'({N{1'b1}}));
        for (int i = 0; i < N; i++) begin
          if (fq[i].size() > 0) acc_data[i*DW +: DW] <= fq[i].pop_front();
          else check("pop_nonempty_lane", 64'(fq[i].size()), 64'd1);
        end
      end
      for (int i = 0; i < N; i++) begin
        while (pend[i].size() > 0) fq[i].push_back(pend[i].pop_front());
        acc_empty[i] <= (fq[i].size() == 0);
      end
    end
  end

  // output monitor / scoreboard
  logic            pv;
  logic            pacc;
  logic [N*OW-1:0] pdata;
  initial begin
    pv = 1'b0; pacc = 1'b0; pdata = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      pacc = 1'b0;
    end else begin
      if (pv && !pacc) begin
        check("valid_held", 64'(out_valid), 64'd1);
        check("data_stable", 64'(out_data), 64'(pdata));
      end
      if (done) n_done++;
      if (acc_rd_en != '0) n_rd++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_row: got %h expected no row", out_data);
        end else begin
          check("row", 64'(out_data), 64'(exp_q.pop_front()));
        end
        n_acc++;
      end
      pv = out_valid;
      pacc = out_valid && out_ready;
      pdata = out_data;
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int sh, input logic relu);
    start = 1'b1;
    shift = 5'(sh);
    relu_en = relu;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_row(input logic [N*DW-1:0] r, input int skip_lane);
    for (int i = 0; i < N; i++)
      if (i != skip_lane) pend[i].push_back(r[i*DW +: DW]);
  endtask

  task automatic wait_done(input string name, input int budget);
    int base;
    int k;
    base = n_done;
    k = 0;
    while (n_done == base && k < budget) begin
      tick();
      k++;
    end
    check(name, 64'(n_done - base), 64'd1);
  endtask

  task automatic set_vec(input int k, input int sh, input logic relu, input int xv[N], input int yv[N]);
    tbl[k].sh = 5'(sh);
    tbl[k].relu = relu;
    for (int i = 0; i < N; i++) begin
      tbl[k].x[i] = DW'(xv[i]);
      tbl[k].y[i] = OW'(yv[i]);
    end
  endtask

  int k;
  int base;
  int rd0;
  int done_cycle;
  int sh;
  logic rl;

  initial begin
    rst = 1'b1; start = 1'b0; shift = '0; relu_en = 1'b0; out_ready = 1'b0;

    xs = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    ys = '{63, 63, 63, 63, 63, 63, 63, 63};
    set_vec(0, 4, 1'b0, xs, ys);
    xs = '{-1000, 5000, 7, -9, -1000, 5000, 7, -9};
    ys = '{-125, 127, 1, -1, -125, 127, 1, -1};
    set_vec(1, 3, 1'b0, xs, ys);
    ys = '{0, 127, 1, 0, 0, 127, 1, 0};
    set_vec(2, 3, 1'b1, xs, ys);
    xs = '{100, -200, 127, -128, 128, -129, 0, -1};
    ys = '{100, -128, 127, -128, 127, -128, 0, -1};
    set_vec(3, 0, 1'b0, xs, ys);
    xs = '{8388607, -8388608, 4194304, 4194303, -4194304, -4194305, 0, 1};
    ys = '{1, -1, 1, 0, 0, -1, 0, 0};
    set_vec(4, 23, 1'b0, xs, ys);
    xs = '{3, -3, 255, 256, -1, 2, 1, -2};
    ys = '{2, 0, 127, 127, 0, 1, 1, 0};
    set_vec(5, 1, 1'b1, xs, ys);

    // reset values
    tick(3);
    check("rst_rd_en", 64'(acc_rd_en), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));

    // start coinciding with reset is ignored
    start = 1'b1;
    tick();
    check("start_in_rst_busy", 64'(busy), 64'd0);
    start = 1'b0;
    rst = 1'b0;
    tick(2);
    check("after_rst_busy", 64'(busy), 64'd0);

    // basic drain with exact cycle timing, FIFOs preloaded, out_ready tied high
    for (int r = 0; r < 8; r++) begin
      push_row(tbl[0].x, -1);
      exp_q.push_back({N{8'(63)}});
    end
    out_ready = 1'b1;
    tick(2);
    pulse_start(4, 1'b0);
    done_cycle = 0;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("c1_busy", 64'(busy), 64'd1);
        check("c1_rd_en", 64'(acc_rd_en), 64'({N{1'b1}}));
      end
      if (c == 2) begin
        check("c2_rd_en", 64'(acc_rd_en), 64'd0);
        check("c2_state", 64'(state_dbg), 64'(ST_CAPTURE));
      end
      if (c == 3) check("c3_out_valid", 64'(out_valid), 64'd1);
      if (done && done_cycle == 0) done_cycle = c;
    end
    tick();
    check("done_cycle", 64'(done_cycle), 64'd25);
    check("basic_rows_drained", 64'(exp_q.size()), 64'd0);

    // table vectors: each record drives a full tile of identical rows
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < 8; r++) begin
        push_row(tbl[t].x, -1);
        exp_q.push_back(tbl[t].y);
      end
      pulse_start(int'(tbl[t].sh), tbl[t].relu);
      wait_done("tbl_done", 100);
      check("tbl_rows_drained", 64'(exp_q.size()), 64'd0);
    end

    // backpressure in HOLD, with an ignored start while busy
    sh = $urandom_range(0, 23);
    rl = 1'($urandom_range(0, 1));
    for (int r = 0; r < 8; r++) begin
      rows[r] = rand_row(sh);
      push_row(rows[r], -1);
      exp_q.push_back(ref_row(rows[r], sh, rl));
    end
    out_ready = 1'b0;
    pulse_start(sh, rl);
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check("bp_reached_hold", 64'(out_valid), 64'd1);
    rd0 = n_rd;
    for (int c = 0; c < 10; c++) begin
      start = (c == 5);
      shift = 5'd0;
      relu_en = ~rl;
      tick();
    end
    start = 1'b0;
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_no_pop", 64'(n_rd - rd0), 64'd0);
    out_ready = 1'b1;
    wait_done("bp_done", 100);
    check("bp_rows_drained", 64'(exp_q.size()), 64'd0);

    // uneven fill: lane 5 empty until later
    sh = $urandom_range(0, 23);
    rl = 1'($urandom_range(0, 1));
    for (int r = 0; r < 8; r++) begin
      rows[r] = rand_row(sh);
      push_row(rows[r], 5);
      exp_q.push_back(ref_row(rows[r], sh, rl));
    end
    tick(2);
    pulse_start(sh, rl);
    rd0 = n_rd;
    tick(10);
    check("uneven_no_pop", 64'(n_rd - rd0), 64'd0);
    check("uneven_busy", 64'(busy), 64'd1);
    pend[5].push_back(rows[0][5*DW +: DW]);
    @(negedge clk);
    check("uneven_pop_before_flag", 64'(acc_rd_en), 64'd0);
    @(negedge clk);
    check("uneven_pop_after_flag", 64'(acc_rd_en), 64'({N{1'b1}}));
    tick();
    for (int r = 1; r < 8; r++) pend[5].push_back(rows[r][5*DW +: DW]);
    wait_done("uneven_done", 100);
    check("uneven_rows_drained", 64'(exp_q.size()), 64'd0);

    // timeout with all lanes empty
    base = n_done;
    pulse_start(0, 1'b0);
    for (int c = 1; c <= 256; c++) begin
      @(negedge clk);
      if (c == 255) begin
        check("to_c255_busy", 64'(busy), 64'd1);
        check("to_c255_err", 64'(err_timeout), 64'd0);
      end
      if (c == 256) begin
        check("to_c256_busy", 64'(busy), 64'd0);
        check("to_c256_err", 64'(err_timeout), 64'd1);
      end
    end
    tick();
    check("to_no_done", 64'(n_done - base), 64'd0);
    check("to_err_sticky", 64'(err_timeout), 64'd1);
    sh = $urandom_range(0, 23);
    pulse_start(sh, 1'b0);
    check("to_err_cleared", 64'(err_timeout), 64'd0);
    for (int r = 0; r < 8; r++) begin
      rows[r] = rand_row(sh);
      push_row(rows[r], -1);
      exp_q.push_back(ref_row(rows[r], sh, 1'b0));
    end
    wait_done("to_restart_done", 100);

    // reset during HOLD of row 3
    sh = $urandom_range(0, 23);
    rl = 1'($urandom_range(0, 1));
    for (int r = 0; r < 8; r++) begin
      rows[r] = rand_row(sh);
      push_row(rows[r], -1);
      exp_q.push_back(ref_row(rows[r], sh, rl));
    end
    out_ready = 1'b1;
    pulse_start(sh, rl);
    base = n_acc;
    k = 0;
    while (n_acc < base + 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check("mid_rows_accepted", 64'(n_acc - base), 64'd3);
    check("mid_in_hold", 64'(state_dbg), 64'(ST_HOLD));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rd_en", 64'(acc_rd_en), 64'd0);
    check("mid_rst_state", 64'(state_dbg), 64'(ST_IDLE));
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    for (int r = 0; r < 8; r++) begin
      rows[r] = rand_row(sh);
      push_row(rows[r], -1);
      exp_q.push_back(ref_row(rows[r], sh, rl));
    end
    out_ready = 1'b1;
    pulse_start(sh, rl);
    wait_done("mid_fresh_done", 100);
    check("mid_fresh_drained", 64'(exp_q.size()), 64'd0);

    // randomized tiles: trickled writes, random backpressure, stray starts
    for (int t = 0; t < 8; t++) begin
      sh = $urandom_range(0, 23);
      rl = 1'($urandom_range(0, 1));
      for (int r = 0; r < 8; r++) begin
        rows[r] = rand_row(sh);
        exp_q.push_back(ref_row(rows[r], sh, rl));
      end
      base = n_done;
      pulse_start(sh, rl);
      fork
        begin
          for (int r = 0; r < 8; r++) begin
            push_row(rows[r], -1);
            tick($urandom_range(1, 4));
          end
        end
        begin
          for (int c = 0; c < 600 && n_done == base; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            start = (c == 7);
            shift = 5'($urandom_range(0, 23));
            tick();
          end
          start = 1'b0;
        end
      join
      check("rand_done", 64'(n_done - base), 64'd1);
    end
    out_ready = 1'b1;
    tick(3);
    check("final_rows_drained", 64'(exp_q.size()), 64'd0);
    check("final_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
